div_hilo_unit: RTL and testbench

Multi-cycle DIV/DIVU execution unit and HI/LO register file for the MIPS EX stage.
- Accepts operands from the pipeline and applies signed-to-magnitude conversion.
- Drives the team's combinational unsigned array `divide` (dividend, divisor -> quotient, remainder) as a DIV_CYCLES multicycle path.
- Applies the sign fix-up, writes HI (remainder) and LO (quotient), and stalls the pipeline via busy.
- Also services MTHI/MTLO and provides HI/LO to MFHI/MFLO.

---
 rtl/div_hilo_unit_pkg.sv | 20 ++
 rtl/div_hilo_unit_if.sv | 38 +++
 rtl/div_hilo_unit_divide.sv | 41 ++++
 rtl/div_hilo_unit.sv | 135 +++++++++++++
 tb/tb_div_hilo_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_hilo_unit_pkg.sv
// ============================================================================
// Module      : mips_div_pkg
// Description : Shared types and constants for the DIV/DIVU + HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

  localparam int DIV_CYCLES_DEFAULT = 4;
  localparam int CNT_W              = 4;

endpackage : mips_div_pkg

`default_nettype wire

// File: rtl/div_hilo_unit_if.sv
// ============================================================================
// Module      : div_hilo_unit_if
// Description : Pipeline-side bundle for the divide unit and HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_hilo_unit_if;

  logic        start;
  logic        is_signed;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side
  modport master (
    output start, is_signed, rs_val, rt_val, flush, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  // Execution unit side
  modport slave (
    input  start, is_signed, rs_val, rt_val, flush, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );

endinterface : div_hilo_unit_if

`default_nettype wire

// File: rtl/div_hilo_unit_divide.sv
// ============================================================================
// Module      : divide
// Description : Combinational unsigned restoring-division array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divide #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_dvd;
  logic             w_ge;

  // One restoring step per dividend bit, MSB first.
  always_comb begin
    w_rem    = '0;
    w_dvd    = dividend;
    w_ge     = 1'b0;
    quotient = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_rem = {w_rem[WIDTH-1:0], w_dvd[WIDTH-1]};
      w_dvd = w_dvd << 1;
      w_ge  = (w_rem >= {1'b0, divisor});
      if (w_ge) begin
        w_rem = w_rem - {1'b0, divisor};
      end
      quotient = {quotient[WIDTH-2:0], w_ge};
    end
    remainder = w_rem[WIDTH-1:0];
  end

endmodule : divide

`default_nettype wire

// File: rtl/div_hilo_unit.sv
// ============================================================================
// Module      : div_hilo_unit
// Description : Multi-cycle DIV/DIVU unit with HI/LO register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_hilo_unit
  import mips_div_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  div_hilo_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  function automatic logic [31:0] fixup(input logic [31:0] x, input logic neg);
    return neg ? (32'd0 - x) : x;
  endfunction

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_wb;

  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_zero_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic        r_div_by_zero;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Array inputs come only from the latched magnitudes, so they hold for all of RUN.
  divide u_divide (
    .dividend  (r_mag_a),
    .divisor   (r_mag_b),
    .quotient  (w_quot),
    .remainder (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_wb         = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          w_state_next = RUN;
          w_cnt_next   = C_CNT_LOAD;
          w_accept     = 1'b1;
        end
      end
      RUN: begin
        if (bus.flush) begin
          w_state_next = IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = IDLE;
          w_wb         = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero_b <= 1'b0;
    end else if (w_accept) begin
      r_mag_a  <= magnitude(bus.rs_val, bus.is_signed);
      r_mag_b  <= magnitude(bus.rt_val, bus.is_signed);
      r_neg_q  <= bus.is_signed & (bus.rs_val[31] ^ bus.rt_val[31]);
      r_neg_r  <= bus.is_signed & bus.rs_val[31];
      r_zero_b <= (bus.rt_val == 32'd0);
    end
  end

  // MT writes land first so a same-edge division writeback overrides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi          <= '0;
      r_lo          <= '0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      if (bus.hi_we) r_hi <= bus.wdata;
      if (bus.lo_we) r_lo <= bus.wdata;
      if (w_wb && !r_zero_b) begin
        r_hi <= fixup(w_rem,  r_neg_r);
        r_lo <= fixup(w_quot, r_neg_q);
      end
      r_done        <= w_wb;
      r_div_by_zero <= w_wb & r_zero_b;
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule : div_hilo_unit

`default_nettype wire

// File: tb/tb_div_hilo_unit.sv
// ============================================================================
// Module      : tb_div_hilo_unit
// Description : Directed self-checking bench for div_hilo_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_hilo_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_hilo_unit_if bus ();

  div_hilo_unit #(.DIV_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one division and wait (bounded) for done; leaves time in the done cycle.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic got);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.rs_val    = a;
    bus.rt_val    = b;
    step();
    bus.start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks += 5;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
  endtask

  task automatic test_divu_latency();
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks += 2;
      if (bus.busy !== 1'(c <= 4)) begin
        errors++; $display("FAIL latency_busy c%0d: got %b want %b", c, bus.busy, (c <= 4));
      end
      if (bus.done !== 1'(c == 5)) begin
        errors++; $display("FAIL latency_done c%0d: got %b want %b", c, bus.done, (c == 5));
      end
      if (c == 2) begin
        bus.start = 1'b1; bus.rs_val = 32'd200; bus.rt_val = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (c < 5) step();
    end
    checks += 2;
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", bus.lo); end
    if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", bus.hi); end
    step();
    checks += 2;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", bus.done); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_start_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_signed();
    logic        got;
    logic        sg  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] a   [5] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] b   [5] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] elo [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h7FFFFFFC, 32'h80000000, 32'd3};
    logic [31:0] ehi [5] = '{32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF};
    for (int v = 0; v < 5; v++) begin
      do_div(sg[v], a[v], b[v], got);
      checks += 3;
      if (got !== 1'b1) begin errors++; $display("FAIL vec%0d_done: got %b want 1", v, got); end
      if (bus.lo !== elo[v]) begin errors++; $display("FAIL vec%0d_lo: got %h want %h", v, bus.lo, elo[v]); end
      if (bus.hi !== ehi[v]) begin errors++; $display("FAIL vec%0d_hi: got %h want %h", v, bus.hi, ehi[v]); end
      step();
    end
  endtask

  task automatic test_div_by_zero();
    logic got;
    bus.hi_we = 1'b1; bus.wdata = 32'h11;
    step();
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22;
    step();
    bus.lo_we = 1'b0;
    do_div(1'b1, 32'd5, 32'd0, got);
    checks += 4;
    if (got !== 1'b1) begin errors++; $display("FAIL dbz_done: got %b want 1", got); end
    if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero); end
    if (bus.hi !== 32'h11) begin errors++; $display("FAIL dbz_hi: got %h want 00000011", bus.hi); end
    if (bus.lo !== 32'h22) begin errors++; $display("FAIL dbz_lo: got %h want 00000022", bus.lo); end
    step();
    checks += 1;
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_pulse: got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_flush();
    logic got;
    logic seen;
    bus.start = 1'b1; bus.flush = 1'b1; bus.is_signed = 1'b0; bus.rs_val = 32'd50; bus.rt_val = 32'd5;
    step();
    bus.start = 1'b0; bus.flush = 1'b0;
    checks += 1;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_with_flush: got busy %b want 0", bus.busy); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks += 1;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      step();
    end
    checks += 3;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_done: got done seen=%b want 0", seen); end
    if (bus.hi !== 32'h11) begin errors++; $display("FAIL flush_hi: got %h want 00000011", bus.hi); end
    if (bus.lo !== 32'h22) begin errors++; $display("FAIL flush_lo: got %h want 00000022", bus.lo); end
    do_div(1'b0, 32'd9, 32'd3, got);
    checks += 3;
    if (got !== 1'b1) begin errors++; $display("FAIL after_flush_done: got %b want 1", got); end
    if (bus.lo !== 32'd3) begin errors++; $display("FAIL after_flush_lo: got %h want 00000003", bus.lo); end
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL after_flush_hi: got %h want 00000000", bus.hi); end
    step();
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 4;
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", bus.lo); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks += 2;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_late_done: got seen=%b want 0", seen); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_late_lo: got %h want 0", bus.lo); end
  endtask

  task automatic test_mt_collision();
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    bus.lo_we = 1'b1; bus.wdata = 32'h0000ABCD;
    step();
    bus.lo_we = 1'b0;
    checks += 3;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL collide_done: got %b want 1", bus.done); end
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL collide_lo: got %h want 0000000e", bus.lo); end
    if (bus.hi !== 32'd2) begin errors++; $display("FAIL collide_hi: got %h want 00000002", bus.hi); end
    step();
  endtask

  task automatic test_mthi_idle();
    bus.hi_we = 1'b1; bus.wdata = 32'h5555AAAA;
    step();
    bus.hi_we = 1'b0;
    checks += 2;
    if (bus.hi !== 32'h5555AAAA) begin errors++; $display("FAIL mthi_hi: got %h want 5555aaaa", bus.hi); end
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL mthi_lo: got %h want 0000000e", bus.lo); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.rs_val    = '0;
    bus.rt_val    = '0;
    bus.flush     = 1'b0;
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b0;
    bus.wdata     = '0;
    test_reset();
    test_divu_latency();
    test_signed();
    test_div_by_zero();
    test_flush();
    test_reset_mid();
    test_mt_collision();
    test_mthi_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_div_hilo_unit

`default_nettype wire
